// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: stalls the pipeline around a single-outstanding data-memory request.
// Optional MEM_ALIGN_CHECK_EN adds misaligned-access detection and the misalign_o port.
module mem_stage_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic [31:0] ALUdata_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RDaddr_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  input  logic        dmem_ack_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUdata_o,
  output logic [4:0]  RDaddr_o
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [4:0]  rdaddr_q, rdaddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_op;
  logic        misalign_det;
  logic        misalign;

  assign mem_op = MemRead_i | MemWrite_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_det = (ALUdata_i[1:0] != 2'b00);
  assign misalign_o   = misalign;
`else
  assign misalign_det = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    regwrite_d   = regwrite_q;
    memtoreg_d   = memtoreg_q;
    rdaddr_d     = rdaddr_q;
    rdata_d      = rdata_q;
    dmem_req_o   = 1'b0;
    dmem_we_o    = we_q;
    dmem_addr_o  = addr_q;
    dmem_wdata_o = wdata_q;
    stall_o      = 1'b0;
    RegWrite_o   = 1'b0;
    MemtoReg_o   = 1'b0;
    ReadData_o   = 32'd0;
    ALUdata_o    = ALUdata_i;
    RDaddr_o     = RDaddr_i;
    misalign     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_op && misalign_det) begin
          misalign = 1'b1;
        end else if (mem_op) begin
          stall_o    = 1'b1;
          addr_d     = ALUdata_i;
          wdata_d    = WriteData_i;
          we_d       = MemWrite_i;  // store wins when both are set
          regwrite_d = RegWrite_i;
          memtoreg_d = MemtoReg_i;
          rdaddr_d   = RDaddr_i;
          state_d    = S_WAIT;
        end else begin
          RegWrite_o = RegWrite_i;
          MemtoReg_o = MemtoReg_i;
        end
      end
      S_WAIT: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        ALUdata_o  = addr_q;
        RDaddr_o   = rdaddr_q;
        if (dmem_ack_i) begin
          rdata_d = we_q ? 32'd0 : dmem_rdata_i;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        RegWrite_o = regwrite_q;
        MemtoReg_o = memtoreg_q;
        ALUdata_o  = addr_q;
        RDaddr_o   = rdaddr_q;
        ReadData_o = rdata_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Reset must quiet every output immediately, not just at the next edge.
    if (rst_i) begin
      dmem_req_o = 1'b0;
      stall_o    = 1'b0;
      RegWrite_o = 1'b0;
      MemtoReg_o = 1'b0;
      ReadData_o = 32'd0;
      ALUdata_o  = 32'd0;
      RDaddr_o   = 5'd0;
      misalign   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdaddr_q   <= 5'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rdaddr_q   <= rdaddr_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: expected MEM/WB results are queued when an
// op is issued and popped when the DUT presents them.
module tb_mem_stage_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [31:0] ALUdata_i, WriteData_i;
  logic [4:0]  RDaddr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic        dmem_ack_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUdata_o;
  logic [4:0]  RDaddr_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  typedef struct packed {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic [31:0] rdata;
  } wb_t;

  wb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  mem_stage_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .ALUdata_i(ALUdata_i), .WriteData_i(WriteData_i), .RDaddr_i(RDaddr_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata_i), .dmem_ack_i(dmem_ack_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ReadData_o(ReadData_o), .ALUdata_o(ALUdata_o), .RDaddr_o(RDaddr_o)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_o(misalign_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rda);
    MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemtoReg_i = m2r;
    ALUdata_i = alu; WriteData_i = wd; RDaddr_i = rda;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
  endtask

  // Pop the oldest expected writeback and compare it with the live MEM/WB outputs.
  task automatic check_wb(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk1({tag, "_rw"}, RegWrite_o, e.rw);
      chk1({tag, "_m2r"}, MemtoReg_o, e.m2r);
      chk32({tag, "_alu"}, ALUdata_o, e.alu);
      chk32({tag, "_rd"}, 32'(RDaddr_o), 32'(e.rd));
      chk32({tag, "_rdata"}, ReadData_o, e.rdata);
    end
  endtask

  // Issue one memory op; ack arrives in WAIT cycle number ack_dly (>=1).
  task automatic mem_op(input string tag, input logic rd, input logic wr,
                        input logic rw, input logic m2r, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rda,
                        input int ack_dly, input logic [31:0] rdata);
    int stalls;
    int reqs;
    wb_t e;
    e.rw = rw; e.m2r = m2r; e.alu = addr; e.rd = rda;
    e.rdata = wr ? 32'd0 : rdata;
    drive(rd, wr, rw, m2r, addr, wd, rda);
    sb.push_back(e);
    stalls = 0;
    reqs = 0;
    #1;
    chk1({tag, "_c0_stall"}, stall_o, 1'b1);
    chk1({tag, "_c0_bubble"}, RegWrite_o | MemtoReg_o, 1'b0);
    chk1({tag, "_c0_req"}, dmem_req_o, 1'b0);
    if (stall_o) stalls++;
    for (int k = 1; k <= ack_dly; k++) begin
      next_cycle();
      dmem_ack_i   = (k == ack_dly);
      dmem_rdata_i = (k == ack_dly) ? rdata : $urandom;
      #1;
      if (stall_o) stalls++;
      if (dmem_req_o) reqs++;
      chk32({tag, "_addr"}, dmem_addr_o, addr);
      chk1({tag, "_we"}, dmem_we_o, wr);
      if (wr) chk32({tag, "_wdata"}, dmem_wdata_o, wd);
      chk1({tag, "_w_bubble"}, RegWrite_o | MemtoReg_o, 1'b0);
    end
    // DONE: pending-looking inputs must be ignored.
    next_cycle();
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'hFFFF_FFFF;
    drive(1'b1, 1'b1, ~rw, ~m2r, 32'hA5A5_A5A4, 32'h5A5A_5A5A, ~rda);
    #1;
    chk1({tag, "_done_stall"}, stall_o, 1'b0);
    chk1({tag, "_done_req"}, dmem_req_o, 1'b0);
    check_wb(tag);
    chk32({tag, "_stalls"}, 32'(stalls), 32'(1 + ack_dly));
    chk32({tag, "_reqs"}, 32'(reqs), 32'(ack_dly));
    next_cycle();
    dmem_ack_i = 1'b0;
    nop();
    #1;
    chk1({tag, "_idle_stall"}, stall_o, 1'b0);
    chk1({tag, "_idle_req"}, dmem_req_o, 1'b0);
  endtask

  initial begin
    // Reset with busy-looking inputs: everything must read as quiet.
    rst_i = 1'b1;
    dmem_ack_i = 1'b0;
    dmem_rdata_i = 32'h0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h55, 32'h77, 5'd9);
    #2;
    chk1("rst_stall", stall_o, 1'b0);
    chk1("rst_req", dmem_req_o, 1'b0);
    chk1("rst_rw", RegWrite_o, 1'b0);
    chk1("rst_m2r", MemtoReg_o, 1'b0);
    chk32("rst_alu", ALUdata_o, 32'd0);
    chk32("rst_rd", 32'(RDaddr_o), 32'd0);
    chk32("rst_rdata", ReadData_o, 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    chk1("rst_misalign", misalign_o, 1'b0);
`endif
    nop();
    next_cycle();
    next_cycle();
    rst_i = 1'b0;

    // ALU op passes straight through.
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd3);
    sb.push_back('{rw: 1'b1, m2r: 1'b0, alu: 32'h55, rd: 5'd3, rdata: 32'd0});
    #1;
    chk1("alu_stall", stall_o, 1'b0);
    chk1("alu_req", dmem_req_o, 1'b0);
    check_wb("alu");

    // Load at 0x100, ack in the 4th WAIT cycle.
    next_cycle();
    mem_op("ld", 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7, 4, 32'hDEAD_BEEF);

    // Store at 0x204, ack in the first WAIT cycle.
    next_cycle();
    mem_op("st", 1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'h1234_5678, 5'd0, 1, 32'hCAFE_F00D);

    // Read and write together: store wins, no load data.
    next_cycle();
    mem_op("rw", 1'b1, 1'b1, 1'b1, 1'b1, 32'h308, 32'h0BAD_F00D, 5'd12, 2, 32'h1111_2222);

    // Ack in IDLE is ignored.
    next_cycle();
    dmem_ack_i = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd31);
    sb.push_back('{rw: 1'b1, m2r: 1'b1, alu: 32'h40, rd: 5'd31, rdata: 32'd0});
    #1;
    check_wb("idle_ack");
    next_cycle();
    dmem_ack_i = 1'b0;
    nop();
    #1;
    chk1("idle_ack_stall", stall_o, 1'b0);
    chk1("idle_ack_req", dmem_req_o, 1'b0);

    // Reset in the 2nd WAIT cycle, then a stray ack.
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd5);
    next_cycle();
    #1;
    chk1("rstw_req1", dmem_req_o, 1'b1);
    next_cycle();
    rst_i = 1'b1;
    nop();
    #1;
    chk1("rstw_req_async", dmem_req_o, 1'b0);
    chk1("rstw_stall_async", stall_o, 1'b0);
    next_cycle();
    dmem_ack_i = 1'b1;
    dmem_rdata_i = 32'h9999_9999;
    next_cycle();
    dmem_ack_i = 1'b0;
    #2;
    rst_i = 1'b0;
    next_cycle();
    #1;
    chk1("rstw_idle_stall", stall_o, 1'b0);
    chk1("rstw_idle_req", dmem_req_o, 1'b0);
    chk32("rstw_rdata", ReadData_o, 32'd0);
    chk32("rstw_addr", dmem_addr_o, 32'd0);
    chk1("rstw_rw", RegWrite_o, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4);
    #1;
    chk1("mis_req", dmem_req_o, 1'b0);
    chk1("mis_pulse", misalign_o, 1'b1);
    chk1("mis_rw", RegWrite_o, 1'b0);
    chk1("mis_stall", stall_o, 1'b0);
    next_cycle();
    nop();
    #1;
    chk1("mis_pulse_end", misalign_o, 1'b0);
    chk1("mis_req_after", dmem_req_o, 1'b0);
`endif

    // A second load after reset recovery still completes normally.
    next_cycle();
    mem_op("ld2", 1'b1, 1'b0, 1'b1, 1'b1, 32'h3FC, 32'h0, 5'd17, 1, 32'h0F0F_0F0F);

    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port MemRead_i  in  1  EX/MEM load control.
REQ-004 SHALL have port MemWrite_i  in  1  EX/MEM store control.
REQ-005 SHALL have port RegWrite_i  in  1  EX/MEM register-write control.
REQ-006 SHALL have port MemtoReg_i  in  1  EX/MEM writeback-select control.
REQ-007 SHALL have port ALUdata_i  in  32  ALU result; memory byte address for loads/stores.
REQ-008 SHALL have port WriteData_i  in  32  store data.
REQ-009 SHALL have port RDaddr_i  in  5  destination register.
REQ-010 SHALL have port dmem_req_o  out  1  memory request, held until ack.
REQ-011 SHALL have port dmem_we_o  out  1  1 = write, 0 = read.
REQ-012 SHALL have port dmem_addr_o  out  32  memory address.
REQ-013 SHALL have port dmem_wdata_o  out  32  memory write data.
REQ-014 SHALL have port dmem_rdata_i  in  32  memory read data, valid when dmem_ack_i=1.
REQ-015 SHALL have port dmem_ack_i  in  1  memory completion; any latency >=1 cycle after request.
REQ-016 SHALL have port stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-017 SHALL have ports RegWrite_o, MemtoReg_o  out  1 each  to MEM/WB.
REQ-018 SHALL have port ReadData_o  out  32  load data to MEM/WB.
REQ-019 SHALL have port ALUdata_o  out  32  ALU result to MEM/WB.
REQ-020 SHALL have port RDaddr_o  out  5  destination register to MEM/WB.
REQ-021 SHALL have port misalign_o  out  1  misaligned-access pulse; present only with MEM_ALIGN_CHECK_EN.

Function
REQ-022 SHALL implement the FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-023 IDLE, MemRead_i=MemWrite_i=0: outputs combinational pass-through of inputs, ReadData_o=0, stall_o=0, dmem_req_o=0.
REQ-024 IDLE, MemRead_i|MemWrite_i=1: stall_o=1 and RegWrite_o=MemtoReg_o=0 (bubble) in the same cycle; at the edge, capture address, wdata, we, RegWrite, MemtoReg and RDaddr, then go to WAIT.
REQ-025 WAIT: dmem_req_o=1 with dmem_addr_o, dmem_we_o and dmem_wdata_o driven from captured registers, stable until ack; stall_o=1; bubble outputs.
REQ-026 WAIT with dmem_ack_i=1 at an edge: register dmem_rdata_i (reads) or 0 (writes) and go to DONE; dmem_req_o drops in DONE.
REQ-027 DONE: stall_o=0; outputs driven from captured registers and registered rdata; inputs ignored; next edge unconditionally returns to IDLE.
REQ-028 Load result SHALL reach MEM/WB at the first edge after the ack edge; minimum memory-op occupancy is 3 cycles (ack in the first WAIT cycle).
REQ-029 MemRead_i and MemWrite_i both 1: store takes priority, dmem_we_o=1, ReadData_o=0.
REQ-030 dmem_ack_i in IDLE or DONE: ignored, no state change.
REQ-031 Addresses and data: 32-bit, passed unmodified, with no byte enables; word access only.

Reset
REQ-032 rst_i=1 SHALL immediately force IDLE, clear all captured and rdata registers to 0, and drop dmem_req_o and stall_o, including mid-WAIT; a pending ack is discarded.
REQ-033 While rst_i=1: RegWrite_o=MemtoReg_o=0, data outputs 0, misalign_o=0.

Configuration
REQ-034 With MEM_ALIGN_CHECK_EN defined: an IDLE memory op with ALUdata_i[1:0]!=0 SHALL issue no request, give stall_o=0, output a bubble, pulse misalign_o=1 for that cycle, and stay in IDLE.
REQ-035 Without MEM_ALIGN_CHECK_EN: misalign_o is absent and low address bits are not checked.

Verification
REQ-036 ALU op RegWrite_i=1, ALUdata_i=0x0000_0055, RDaddr_i=3 -> same cycle RegWrite_o=1, ALUdata_o=0x55, RDaddr_o=3, stall_o=0.
REQ-037 Load addr 0x100, ack 4 cycles later with rdata 0xDEAD_BEEF -> stall_o high 5 cycles, dmem_addr_o=0x100 stable, DONE shows ReadData_o=0xDEADBEEF, MemtoReg_o=1.
REQ-038 Store addr 0x204, data 0x1234_5678, ack next cycle -> dmem_we_o=1, dmem_wdata_o=0x12345678, exactly one request, ReadData_o=0.
REQ-039 rst_i asserted in the 2nd WAIT cycle, then ack pulse -> dmem_req_o=0 asynchronously, state IDLE, ack ignored, outputs zero.
REQ-040 MEM_ALIGN_CHECK_EN defined, load at 0x102 -> dmem_req_o stays 0, misalign_o=1 for one cycle, RegWrite_o=0, stall_o=0.
